// File: rtl/char_motion_if.sv
// Button, collision and sprite-position bundle between the game logic
// (master) and one character motion controller (slave).
interface char_motion_if #(
  parameter int JLW = 2
) ();
  logic           respawn;
  logic           freeze;
  logic           left;
  logic           right;
  logic           jump;
  logic           on_ground;
  logic           hit_ceiling;
  logic [9:0]     x;
  logic [9:0]     y;
  logic [6:0]     sprite_control;
  logic [1:0]     state_o;
  logic [JLW-1:0] jumps_left;

  modport master (
    output respawn, freeze, left, right, jump, on_ground, hit_ceiling,
    input  x, y, sprite_control, state_o, jumps_left
  );

  modport slave (
    input  respawn, freeze, left, right, jump, on_ground, hit_ceiling,
    output x, y, sprite_control, state_o, jumps_left
  );
endinterface

// File: rtl/char_motion_ctrl.sv
// Player movement controller: walking, multi-jump with decelerating ascent,
// accelerating fall, walk animation, freeze and respawn.
module char_motion_ctrl #(
  parameter int X_SPAWN     = 500,
  parameter int Y_SPAWN     = 600,
  parameter int CHAR_W      = 64,
  parameter int CHAR_H      = 100,
  parameter int SCREEN_W    = 1024,
  parameter int SCREEN_H    = 768,
  parameter int CW          = 20,
  parameter int WALK_DIV    = 425000,
  parameter int AIR_DIV     = 600000,
  parameter int JUMP_DIV0   = 200000,
  parameter int JUMP_DIVMAX = 800000,
  parameter int FALL_DIV0   = 800000,
  parameter int FALL_DIVMIN = 150000,
  parameter int DIV_STEP    = 20000,
  parameter int JUMP_HEIGHT = 200,
  parameter int APEX_SLOW   = 175,
  parameter int MAX_JUMPS   = 2,
  parameter int ANIM_FRAMES = 8,
  parameter int ANIM_STEP   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  char_motion_if.slave  bus
);

  localparam int JLW = $clog2(MAX_JUMPS + 1);

  localparam logic [9:0]    FLOOR_Y  = 10'(SCREEN_H - 2 - CHAR_H);
  localparam logic [9:0]    X_MAX    = 10'(SCREEN_W - CHAR_W);
  localparam logic [CW-1:0] WALK_M1  = CW'(WALK_DIV - 1);
  localparam logic [CW-1:0] AIR_M1   = CW'(AIR_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MOVE = 2'b01,
    FALL = 2'b10,
    JUMP = 2'b11
  } state_t;

  state_t         state_reg;
  logic [9:0]     x_reg;
  logic [9:0]     y_reg;
  logic [9:0]     y_start_reg;
  logic           facing_reg;
  logic [3:0]     frame_reg;
  logic [JLW-1:0] jumps_left_reg;
  logic [CW-1:0]  cx_reg;
  logic [CW-1:0]  cy_reg;
  logic [CW-1:0]  jdiv_reg;
  logic [CW-1:0]  fdiv_reg;
  logic           jump_q_reg;

  // Horizontal intent and divider selection (ground vs air speed).
  logic          dir_pos;
  logic          dir_neg;
  logic          moving;
  logic          grounded_state;
  logic [CW-1:0] h_div_m1;
  logic          h_step;

  assign dir_pos        = bus.right & ~bus.left;
  assign dir_neg        = bus.left & ~bus.right;
  assign moving         = dir_pos | dir_neg;
  assign grounded_state = ~state_reg[1];
  assign h_div_m1       = grounded_state ? WALK_M1 : AIR_M1;
  assign h_step         = moving && (cx_reg == h_div_m1);

  logic [CW-1:0] cx_next;
  logic [9:0]    x_next;
  logic [3:0]    frame_inc;
  logic [3:0]    frame_next;
  logic          facing_next;

  assign frame_inc = (frame_reg == 4'(ANIM_FRAMES - 1)) ? 4'd0 : frame_reg + 4'd1;

  // Horizontal divider, wall clamping, facing and animation frame.
  always_comb begin
    cx_next     = '0;
    x_next      = x_reg;
    frame_next  = frame_reg;
    facing_next = facing_reg;
    if (dir_pos) begin
      facing_next = 1'b1;
    end else if (dir_neg) begin
      facing_next = 1'b0;
    end
    if (moving) begin
      if (h_step) begin
        cx_next = '0;
        if (dir_pos && (x_reg < X_MAX)) begin
          x_next = x_reg + 10'd1;
        end else if (dir_neg && (x_reg != 10'd0)) begin
          x_next = x_reg - 10'd1;
        end
      end else begin
        cx_next = cx_reg + 1'b1;
      end
    end
    if (h_step && (!grounded_state || ((x_next % 10'(ANIM_STEP)) == 10'd0))) begin
      frame_next = frame_inc;
    end
  end

  // Vertical stepping helpers for the rise and fall phases.
  logic          jedge;
  logic          can_jump;
  logic          at_floor;
  logic          up_step;
  logic [9:0]    y_up;
  logic [10:0]   rise_up;
  logic [CW:0]   jdiv_sum;
  logic [CW-1:0] jdiv_inc;
  logic          dn_step;
  logic [9:0]    y_dn;
  logic [CW-1:0] fdiv_dec;

  assign jedge    = bus.jump & ~jump_q_reg;
  assign can_jump = jedge && (jumps_left_reg != '0);
  assign at_floor = (y_reg == FLOOR_Y);

  assign up_step  = (cy_reg == (jdiv_reg - 1'b1));
  assign y_up     = (up_step && (y_reg != 10'd0)) ? y_reg - 10'd1 : y_reg;
  assign rise_up  = {1'b0, y_start_reg} - {1'b0, y_up};
  assign jdiv_sum = {1'b0, jdiv_reg} + (CW+1)'(DIV_STEP);
  assign jdiv_inc = (jdiv_sum > (CW+1)'(JUMP_DIVMAX)) ? CW'(JUMP_DIVMAX) : jdiv_sum[CW-1:0];

  assign dn_step  = (cy_reg == (fdiv_reg - 1'b1));
  assign y_dn     = (dn_step && (y_reg < FLOOR_Y)) ? y_reg + 10'd1 : y_reg;
  assign fdiv_dec = (fdiv_reg > CW'(FALL_DIVMIN + DIV_STEP)) ? fdiv_reg - CW'(DIV_STEP)
                                                             : CW'(FALL_DIVMIN);

  // Movement FSM: reset/respawn, freeze, jump entry, then per-state update.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.respawn) begin
      state_reg      <= IDLE;
      x_reg          <= 10'(X_SPAWN);
      y_reg          <= 10'(Y_SPAWN);
      y_start_reg    <= 10'(Y_SPAWN);
      facing_reg     <= 1'b1;
      frame_reg      <= 4'd0;
      jumps_left_reg <= JLW'(MAX_JUMPS);
      cx_reg         <= '0;
      cy_reg         <= '0;
      jdiv_reg       <= CW'(JUMP_DIV0);
      fdiv_reg       <= CW'(FALL_DIV0);
      jump_q_reg     <= 1'b0;
    end else begin
      jump_q_reg <= bus.jump;
      if (!bus.freeze) begin
        cx_reg     <= cx_next;
        x_reg      <= x_next;
        facing_reg <= facing_next;
        frame_reg  <= frame_next;
        if (can_jump) begin
          state_reg      <= JUMP;
          y_start_reg    <= y_reg;
          jumps_left_reg <= jumps_left_reg - 1'b1;
          cy_reg         <= '0;
          jdiv_reg       <= CW'(JUMP_DIV0);
        end else begin
          case (state_reg)
            IDLE, MOVE: begin
              if (!bus.on_ground && !at_floor) begin
                state_reg <= FALL;
                fdiv_reg  <= CW'(FALL_DIV0);
                cy_reg    <= '0;
              end else if (moving) begin
                state_reg <= MOVE;
              end else begin
                state_reg <= IDLE;
                frame_reg <= 4'd0;
              end
            end
            JUMP: begin
              y_reg <= y_up;
              if (up_step) begin
                cy_reg <= '0;
                if (rise_up >= 11'(APEX_SLOW)) begin
                  jdiv_reg <= jdiv_inc;
                end
              end else begin
                cy_reg <= cy_reg + 1'b1;
              end
              if ((rise_up >= 11'(JUMP_HEIGHT)) || bus.hit_ceiling || (y_up == 10'd0)) begin
                state_reg <= FALL;
                fdiv_reg  <= CW'(FALL_DIV0);
                cy_reg    <= '0;
              end
            end
            default: begin
              if (bus.on_ground || at_floor) begin
                jumps_left_reg <= JLW'(MAX_JUMPS);
                cy_reg         <= '0;
                if (moving) begin
                  state_reg <= MOVE;
                end else begin
                  state_reg <= IDLE;
                  frame_reg <= 4'd0;
                end
              end else begin
                y_reg <= y_dn;
                if (dn_step) begin
                  cy_reg   <= '0;
                  fdiv_reg <= fdiv_dec;
                end else begin
                  cy_reg <= cy_reg + 1'b1;
                end
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.x              = x_reg;
  assign bus.y              = y_reg;
  assign bus.sprite_control = {facing_reg, state_reg[1], (state_reg == IDLE), frame_reg};
  assign bus.state_o        = state_reg;
  assign bus.jumps_left     = jumps_left_reg;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed bench for char_motion_ctrl with small dividers so that every
// step position can be worked out by hand.
module tb_char_motion_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  char_motion_if #(.JLW(2)) bus ();

  char_motion_ctrl #(
    .WALK_DIV(4), .AIR_DIV(6), .JUMP_DIV0(2), .JUMP_DIVMAX(4),
    .FALL_DIV0(4), .FALL_DIVMIN(2), .DIV_STEP(1),
    .JUMP_HEIGHT(10), .APEX_SLOW(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n           = 1'b0;
    bus.respawn     = 1'b0;
    bus.freeze      = 1'b0;
    bus.left        = 1'b0;
    bus.right       = 1'b0;
    bus.jump        = 1'b0;
    bus.on_ground   = 1'b0;
    bus.hit_ceiling = 1'b0;

    // Reset
    step(3);
    check_val("rst_x", bus.x, 500);
    check_val("rst_y", bus.y, 600);
    check_val("rst_sprite", bus.sprite_control, 7'b1010000);
    check_val("rst_state", bus.state_o, 2'b00);
    check_val("rst_jumps", bus.jumps_left, 2);

    // Walk right 40 cycles: 10 steps, frame advances at x=504
    rst_n = 1'b1;
    bus.on_ground = 1'b1;
    bus.right = 1'b1;
    step(40);
    check_val("walk_x", bus.x, 510);
    check_val("walk_state", bus.state_o, 2'b01);
    check_val("walk_sprite", bus.sprite_control, 7'b1000001);

    // Walk left: one px per 4 cycles, facing cleared
    bus.right = 1'b0;
    bus.left = 1'b1;
    step(4);
    check_val("left_x1", bus.x, 509);
    check_val("left_facing", bus.sprite_control[6], 0);
    step(4);
    check_val("left_x2", bus.x, 508);
    check_val("left_sprite", bus.sprite_control, 7'b0000001);

    // Release: back to IDLE, frame forced to 0
    bus.left = 1'b0;
    step(1);
    check_val("idle_state", bus.state_o, 2'b00);
    check_val("idle_sprite", bus.sprite_control, 7'b0010000);

    // Single jump from y=600
    bus.jump = 1'b1;
    step(1);
    check_val("jump_state", bus.state_o, 2'b11);
    check_val("jump_jl", bus.jumps_left, 1);
    check_val("jump_sprite", bus.sprite_control, 7'b0100000);
    bus.jump = 1'b0;
    bus.on_ground = 1'b0;
    step(16);
    check_val("rise8_y", bus.y, 592);
    check_val("rise8_state", bus.state_o, 2'b11);
    step(3);
    check_val("rise9_y", bus.y, 591);
    step(4);
    check_val("rise10_y", bus.y, 590);
    check_val("apex_state", bus.state_o, 2'b10);
    bus.on_ground = 1'b1;
    step(1);
    check_val("land_state", bus.state_o, 2'b00);
    check_val("land_jl", bus.jumps_left, 2);

    // Jump then ceiling hit
    bus.jump = 1'b1;
    step(1);
    bus.jump = 1'b0;
    bus.on_ground = 1'b0;
    bus.hit_ceiling = 1'b1;
    step(1);
    check_val("ceil_state", bus.state_o, 2'b10);
    bus.hit_ceiling = 1'b0;

    // Fall acceleration: 4 then 3 cycles per px
    step(4);
    check_val("fall1_y", bus.y, 591);
    step(3);
    check_val("fall2_y", bus.y, 592);

    // Double jump from FALL, third pulse ignored
    bus.jump = 1'b1;
    step(1);
    check_val("dbl_state", bus.state_o, 2'b11);
    check_val("dbl_jl", bus.jumps_left, 0);
    bus.jump = 1'b0;
    step(1);
    bus.jump = 1'b1;
    step(1);
    check_val("third_state", bus.state_o, 2'b11);
    check_val("third_jl", bus.jumps_left, 0);
    check_val("third_y", bus.y, 591);
    bus.jump = 1'b0;
    step(21);
    check_val("dbl_apex_y", bus.y, 582);
    check_val("dbl_apex_state", bus.state_o, 2'b10);
    bus.on_ground = 1'b1;
    step(1);
    check_val("dbl_land_jl", bus.jumps_left, 2);

    // Ledge walk-off
    bus.right = 1'b1;
    step(1);
    check_val("ledge_move", bus.state_o, 2'b01);
    bus.on_ground = 1'b0;
    step(1);
    check_val("ledge_fall", bus.state_o, 2'b10);

    // Landing and jump edge together: jump wins
    bus.on_ground = 1'b1;
    bus.jump = 1'b1;
    step(1);
    check_val("landjump_state", bus.state_o, 2'b11);
    check_val("landjump_jl", bus.jumps_left, 1);
    bus.jump = 1'b0;
    bus.right = 1'b0;
    step(1);

    // Freeze mid-jump for 100 cycles
    bus.freeze = 1'b1;
    step(100);
    check_val("frz_x", bus.x, 508);
    check_val("frz_y", bus.y, 582);
    check_val("frz_state", bus.state_o, 2'b11);
    bus.freeze = 1'b0;
    step(1);
    check_val("unfrz_y", bus.y, 581);

    // Respawn while frozen
    bus.freeze = 1'b1;
    bus.respawn = 1'b1;
    step(1);
    check_val("resp_x", bus.x, 500);
    check_val("resp_y", bus.y, 600);
    check_val("resp_state", bus.state_o, 2'b00);
    check_val("resp_jl", bus.jumps_left, 2);
    check_val("resp_sprite", bus.sprite_control, 7'b1010000);
    bus.respawn = 1'b0;

    // Jump held through freeze does not trigger after release
    bus.jump = 1'b1;
    step(2);
    bus.freeze = 1'b0;
    step(1);
    check_val("heldjump_state", bus.state_o, 2'b00);
    check_val("heldjump_jl", bus.jumps_left, 2);
    bus.jump = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
